// File: rtl/ddr5_cmd_encoder.sv
// DDR5 command issue encoder: valid/ready request intake, READ/WRITE and REFRESH
// spacing, and periodic auto-refresh insertion ahead of any held request.
module ddr5_cmd_encoder #(
  parameter int unsigned T_RW_GAP = 4,
  parameter int unsigned T_RFC    = 8,
  parameter int unsigned T_REFI   = 64,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_cmd,
  output logic       req_ready,
  output logic [2:0] cmd_out,
  output logic       refresh_due
);

  localparam logic [1:0] REQ_NOP     = 2'b00;
  localparam logic [1:0] REQ_READ    = 2'b01;
  localparam logic [1:0] REQ_WRITE   = 2'b10;
  localparam logic [1:0] REQ_REFRESH = 2'b11;

  localparam logic [2:0] CODE_NOP     = 3'b000;
  localparam logic [2:0] CODE_REFRESH = 3'b011;

  localparam logic [CNT_W-1:0] RW_LOAD   = CNT_W'(T_RW_GAP - 1);
  localparam logic [CNT_W-1:0] RFC_LOAD  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] REFI_LAST = CNT_W'(T_REFI - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GAP  = 2'b01,
    RFC  = 2'b10
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] gap_cnt;
  logic [CNT_W-1:0] int_cnt;

  logic accept;
  logic auto_ref;
  logic ref_issue;

  // Ready depends only on registered state, never on req_valid.
  assign req_ready = (state == IDLE) && !refresh_due;
  assign accept    = req_valid && req_ready;
  assign auto_ref  = (state == IDLE) && refresh_due;
  assign ref_issue = auto_ref || (accept && (req_cmd == REQ_REFRESH));

  // Command issue and spacing FSM; cmd_out is a one-cycle pulse per issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= CNT_ZERO;
      cmd_out <= CODE_NOP;
    end else begin
      cmd_out <= CODE_NOP;
      case (state)
        IDLE: begin
          if (auto_ref) begin
            cmd_out <= CODE_REFRESH;
            if (T_RFC > 1) begin
              state   <= RFC;
              gap_cnt <= RFC_LOAD;
            end
          end else if (accept) begin
            cmd_out <= {1'b0, req_cmd};
            case (req_cmd)
              REQ_READ, REQ_WRITE: begin
                if (T_RW_GAP > 1) begin
                  state   <= GAP;
                  gap_cnt <= RW_LOAD;
                end
              end
              REQ_REFRESH: begin
                if (T_RFC > 1) begin
                  state   <= RFC;
                  gap_cnt <= RFC_LOAD;
                end
              end
              default: ;
            endcase
          end
        end
        GAP, RFC: begin
          // Counter hitting zero at this edge makes the next edge eligible.
          if (gap_cnt <= CNT_ONE) begin
            state   <= IDLE;
            gap_cnt <= CNT_ZERO;
          end else begin
            gap_cnt <= gap_cnt - CNT_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          gap_cnt <= CNT_ZERO;
        end
      endcase
    end
  end

  // Refresh interval timer; any REFRESH issue restarts it and clears the pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cnt     <= CNT_ZERO;
      refresh_due <= 1'b0;
    end else if (ref_issue) begin
      int_cnt     <= CNT_ZERO;
      refresh_due <= 1'b0;
    end else if (int_cnt == REFI_LAST) begin
      int_cnt     <= CNT_ZERO;
      refresh_due <= 1'b1;
    end else begin
      int_cnt     <= int_cnt + CNT_ONE;
    end
  end

  logic unused_nop;
  assign unused_nop = (REQ_NOP == 2'b00);

endmodule

// File: doc/ddr5_cmd_encoder.md
Name: ddr5_cmd_encoder

Overview:
- Issue-side counterpart of the DDR5 command decoder.
- Accepts 2-bit command names from the controller over a valid/ready handshake and drives the 3-bit DDR5 command code, one cycle per command, NOP otherwise.
- Enforces minimum spacing after READ/WRITE and after REFRESH.
- Inserts periodic auto-refresh, so the decoder downstream sees only legal, spaced command streams.

Parameters:
- T_RW_GAP, 4: minimum cycles between an accepted READ/WRITE and the next acceptance; must be at least 1.
- T_RFC, 8: minimum cycles between any REFRESH issue and the next acceptance or issue; must be at least 1.
- T_REFI, 64: auto-refresh interval in cycles; must exceed T_RFC + T_RW_GAP.
- CNT_W, 16: width of the internal interval and gap counters; must hold T_REFI.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  controller request present.
- req_cmd  in  2  command name: 00 NOP, 01 READ, 10 WRITE, 11 REFRESH.
- req_ready  out  1  encoder can accept a request this cycle.
- cmd_out  out  3  registered DDR5 command code: 000 NOP, 001 READ, 010 WRITE, 011 REFRESH; 1xx is never driven.
- refresh_due  out  1  registered; an auto-refresh is pending.

Behaviour:
- Reset (asynchronous, active-low):
  - cmd_out=000, refresh_due=0, state=IDLE, interval counter=0, gap counter=0.
  - req_ready=1 immediately after release.
  - Asserting reset mid-operation aborts any gap or RFC wait immediately; no pending refresh survives.
- FSM states: IDLE, GAP, RFC.
- req_ready = (state==IDLE) && !refresh_due. It is combinational from registers only and never depends on req_valid.
- Accept: req_valid && req_ready at edge N.
  - cmd_out={0,req_cmd} after edge N, for exactly one cycle.
  - cmd_out returns to 000 after edge N+1 unless a new issue occurs.
  - Latency is 1 cycle.
- Transitions on accept:
  - NOP (00): accepted and consumed, emits 000, stays IDLE, no spacing.
  - READ/WRITE: go to GAP with gap counter = T_RW_GAP-1. If T_RW_GAP==1, stay IDLE, which permits back-to-back issues.
  - REFRESH: go to RFC with gap counter = T_RFC-1. The interval counter restarts at 0, and a pending refresh_due is cleared.
- GAP and RFC: gap counter decrements each cycle and returns to IDLE when it reaches 0 at an edge. The earliest next acceptance is edge N+T_RW_GAP (GAP) or N+T_RFC (RFC).
- Interval counter:
  - Increments every cycle in all states.
  - At an edge where it equals T_REFI-1, it wraps to 0 and sets refresh_due.
  - refresh_due is sticky: a second expiry while still pending keeps it at 1. There is no refresh queue.
- Auto-refresh:
  - Condition: state==IDLE && refresh_due at an edge.
  - Result: cmd_out=011, refresh_due clears, interval counter restarts at 0, and the FSM enters RFC exactly as for a requested REFRESH.
- Priority: a pending auto-refresh beats a held request. req_ready is low that cycle, so the request is not lost; it waits with req_valid held.
- Handshake:
  - The controller must hold req_valid/req_cmd stable until accepted.
  - The encoder's behaviour does not depend on the stability of deasserted requests.

Test Plan:
- Reset: hold rst_n=0, then release → cmd_out=000, refresh_due=0, req_ready=1. Pulse rst_n low mid-cycle → cmd_out=000 asynchronously.
- READ then WRITE (defaults):
  - READ valid, accepted at edge 10 → cmd_out=001 after edge 10, 000 after edge 11.
  - req_ready low between edges 10 and 14.
  - WRITE held valid is accepted at edge 14 → cmd_out=010 after edge 14.
- Requested REFRESH:
  - Accepted at edge 20 → cmd_out=011 for one cycle, req_ready low until edge 28, READ accepted at edge 28.
  - refresh_due stays 0 until 64 edges after edge 20.
- Auto-refresh with no requests:
  - refresh_due rises after the 64th edge after reset release.
  - cmd_out=011 after the 65th edge, refresh_due=0 there, and req_ready returns 8 edges later.
- Collision:
  - Issue READ so that refresh_due asserts during GAP, with a second READ held valid.
  - When GAP ends → REFRESH (011) is issued first, and the held READ is accepted exactly T_RFC=8 edges later.
  - No command is lost or duplicated.
- NOP and back-to-back:
  - req_cmd=00 accepted → cmd_out stays 000, req_ready stays 1 the next cycle.
  - With T_RW_GAP=1, READ/WRITE/READ on consecutive edges → cmd_out 001,010,001 on consecutive cycles.
